store_seq_checker: RTL

STORE_SEQ_CHECKER -- requirements
Module: store_seq_checker

---
 rtl/store_seq_checker_if.sv | 50 +++++
 rtl/store_seq_checker.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/store_seq_checker_if.sv
// Store-sequence checker bus bundle: the monitored processor store bus,
// the expected-store load port, the control strobes and the verdict outputs.
interface store_seq_checker_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    // Monitored processor store bus
    logic             memwrite;
    logic [WIDTH-1:0] dataadr;
    logic [WIDTH-1:0] writedata;

    // Expected-store table load port
    logic             load_en;
    logic [WIDTH-1:0] load_addr;
    logic [WIDTH-1:0] load_data;

    // Control
    logic             start;
    logic             clear;

    // Status and verdict
    logic             busy;
    logic             pass;
    logic             fail;
    logic [1:0]       fail_code;
    logic [WIDTH-1:0] fail_addr;
    logic [WIDTH-1:0] fail_data;
    logic [CW-1:0]    exp_cnt;
    logic [CW-1:0]    match_cnt;

    // Stimulus side: drives the bus, load port and control
    modport master (
        output memwrite, dataadr, writedata,
        output load_en, load_addr, load_data,
        output start, clear,
        input  busy, pass, fail, fail_code, fail_addr, fail_data,
        input  exp_cnt, match_cnt
    );

    // Checker side
    modport slave (
        input  memwrite, dataadr, writedata,
        input  load_en, load_addr, load_data,
        input  start, clear,
        output busy, pass, fail, fail_code, fail_addr, fail_data,
        output exp_cnt, match_cnt
    );
endinterface

// File: rtl/store_seq_checker.sv
// Store-sequence checker: watches a processor store bus and verifies that the
// non-ignored stores occur in exactly the order of a preloaded expected table.
// Ends in a sticky PASS or FAIL verdict (address/data mismatch or timeout).
module store_seq_checker #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int IGN_ADDR = 80,
    parameter int TIMEOUT  = 1024,
    parameter int STRICT   = 1
) (
    input  logic                clk,
    input  logic                reset,
    store_seq_checker_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;    // entry counters, 0..DEPTH
    localparam int AW = $clog2(DEPTH);        // table index
    localparam int TW = $clog2(TIMEOUT) + 1;  // inter-store timer

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PASS,
        ST_FAIL
    } state_t;

    localparam logic [1:0] FC_NONE = 2'd0;
    localparam logic [1:0] FC_ADDR = 2'd1;
    localparam logic [1:0] FC_DATA = 2'd2;
    localparam logic [1:0] FC_TMO  = 2'd3;

    // Registered state
    state_t           r_state;
    logic [CW-1:0]    r_exp_cnt;
    logic [CW-1:0]    r_match_cnt;
    logic [TW-1:0]    r_timer;
    logic [1:0]       r_fail_code;
    logic [WIDTH-1:0] r_fail_addr;
    logic [WIDTH-1:0] r_fail_data;
    logic             r_busy;
    logic             r_pass;
    logic             r_fail;

    // Expected-store table
    logic [WIDTH-1:0] r_tab_addr [DEPTH];
    logic [WIDTH-1:0] r_tab_data [DEPTH];

    // Next-state values
    state_t           w_state_nxt;
    logic [CW-1:0]    w_exp_cnt_nxt;
    logic [CW-1:0]    w_match_cnt_nxt;
    logic [TW-1:0]    w_timer_nxt;
    logic [1:0]       w_fail_code_nxt;
    logic [WIDTH-1:0] w_fail_addr_nxt;
    logic [WIDTH-1:0] w_fail_data_nxt;

    // Store classification against the entry currently awaited
    logic             w_load_ok;
    logic             w_ignored;
    logic             w_store;
    logic             w_addr_ok;
    logic             w_data_ok;
    logic             w_match;
    logic             w_mismatch;
    logic             w_timeout;
    logic [CW-1:0]    w_match_inc;

    assign w_load_ok   = (r_state == ST_IDLE) && bus.load_en && !bus.clear
                         && (r_exp_cnt != CW'(DEPTH));
    assign w_ignored   = bus.dataadr == WIDTH'(IGN_ADDR);
    assign w_store     = bus.memwrite && !w_ignored;
    assign w_addr_ok   = bus.dataadr   == r_tab_addr[r_match_cnt[AW-1:0]];
    assign w_data_ok   = bus.writedata == r_tab_data[r_match_cnt[AW-1:0]];
    assign w_match     = w_store && w_addr_ok && w_data_ok;
    assign w_mismatch  = w_store && !(w_addr_ok && w_data_ok);
    assign w_timeout   = r_timer == TW'(TIMEOUT - 1);
    assign w_match_inc = r_match_cnt + CW'(1);

    // Table write: append one expected store while idle and not full
    // NOTE: the table is plain storage with no reset; its contents only matter
    // below exp_cnt, which reset zeroes, so resetting it would just cost logic.
    always_ff @(posedge clk) begin
        if (w_load_ok) begin
            r_tab_addr[r_exp_cnt[AW-1:0]] <= bus.load_addr;
            r_tab_data[r_exp_cnt[AW-1:0]] <= bus.load_data;
        end
    end

    // Next-state and datapath decisions; clear dominates load and start,
    // a match dominates a mismatch check and the timeout
    // NOTE: every target gets a default first so no path leaves a value
    // unassigned, which would infer a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_exp_cnt_nxt   = r_exp_cnt;
        w_match_cnt_nxt = r_match_cnt;
        w_timer_nxt     = r_timer;
        w_fail_code_nxt = r_fail_code;
        w_fail_addr_nxt = r_fail_addr;
        w_fail_data_nxt = r_fail_data;

        case (r_state)
            ST_IDLE: begin
                if (bus.clear) begin
                    w_exp_cnt_nxt   = '0;
                    w_match_cnt_nxt = '0;
                    w_timer_nxt     = '0;
                end else begin
                    if (w_load_ok) begin
                        w_exp_cnt_nxt = r_exp_cnt + CW'(1);
                    end
                    if (bus.start && (r_exp_cnt != '0)) begin
                        w_state_nxt     = ST_RUN;
                        w_match_cnt_nxt = '0;
                        w_timer_nxt     = '0;
                    end
                end
            end

            ST_RUN: begin
                if (bus.clear) begin
                    w_state_nxt     = ST_IDLE;
                    w_match_cnt_nxt = '0;
                    w_timer_nxt     = '0;
                end else if (w_match) begin
                    w_match_cnt_nxt = w_match_inc;
                    w_timer_nxt     = '0;
                    if (w_match_inc == r_exp_cnt) begin
                        w_state_nxt = ST_PASS;
                    end
                end else if ((STRICT != 0) && w_mismatch) begin
                    w_state_nxt     = ST_FAIL;
                    w_fail_code_nxt = w_addr_ok ? FC_DATA : FC_ADDR;
                    w_fail_addr_nxt = bus.dataadr;
                    w_fail_data_nxt = bus.writedata;
                end else if (w_timeout) begin
                    w_state_nxt     = ST_FAIL;
                    w_fail_code_nxt = FC_TMO;
                    w_fail_addr_nxt = '0;
                    w_fail_data_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end

            ST_PASS, ST_FAIL: begin
                if (bus.clear) begin
                    w_state_nxt     = ST_IDLE;
                    w_match_cnt_nxt = '0;
                    w_timer_nxt     = '0;
                    w_fail_code_nxt = FC_NONE;
                    w_fail_addr_nxt = '0;
                    w_fail_data_nxt = '0;
                end
            end

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register plus registered status flags, synchronous active-low reset
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_exp_cnt   <= '0;
            r_match_cnt <= '0;
            r_timer     <= '0;
            r_fail_code <= FC_NONE;
            r_fail_addr <= '0;
            r_fail_data <= '0;
            r_busy      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_exp_cnt   <= w_exp_cnt_nxt;
            r_match_cnt <= w_match_cnt_nxt;
            r_timer     <= w_timer_nxt;
            r_fail_code <= w_fail_code_nxt;
            r_fail_addr <= w_fail_addr_nxt;
            r_fail_data <= w_fail_data_nxt;
            r_busy      <= (w_state_nxt == ST_RUN);
            r_pass      <= (w_state_nxt == ST_PASS);
            r_fail      <= (w_state_nxt == ST_FAIL);
        end
    end

    assign bus.busy      = r_busy;
    assign bus.pass      = r_pass;
    assign bus.fail      = r_fail;
    assign bus.fail_code = r_fail_code;
    assign bus.fail_addr = r_fail_addr;
    assign bus.fail_data = r_fail_data;
    assign bus.exp_cnt   = r_exp_cnt;
    assign bus.match_cnt = r_match_cnt;

endmodule
